// File: rtl/bb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// bb_uart_tx_arb
//
// Purpose:
//   Two-requester UART transmitter. Round-robin arbitrates two byte sources
//   onto one serial TXD line and sends 8N1 or 8N2 frames, LSB first. The baud
//   divider is owned by this block and restarted at every frame start, so
//   every bit edge is aligned to the frame's start bit.
//
// Parameters:
//   CLK_DIVIDER  clk cycles per bit, 2..1023 (10-bit counter)
//   STOP_BITS    number of stop bit periods, 1 or 2
//
// Ports:
//   clk     in   system clock, all logic on posedge
//   nrst    in   synchronous active-low reset
//   din0    in   byte from requester 0
//   valid0  in   requester 0 has a byte
//   ready0  out  din0 accepted this cycle (combinational)
//   din1    in   byte from requester 1
//   valid1  in   requester 1 has a byte
//   ready1  out  din1 accepted this cycle (combinational)
//   txd     out  serial output, idle high
//   busy    out  frame in progress
//   gnt     out  source index of the current/last frame
//   bdout   out  one-cycle pulse at the end of each bit period
// ---------------------------------------------------------------------------
module bb_uart_tx_arb #(
  parameter int CLK_DIVIDER = 521,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] din0,
  input  logic       valid0,
  output logic       ready0,
  input  logic [7:0] din1,
  input  logic       valid1,
  output logic       ready1,
  output logic       txd,
  output logic       busy,
  output logic       gnt,
  output logic       bdout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [9:0] CNT_LAST  = 10'(CLK_DIVIDER - 1);
  // Stop-bit index of the final stop period (0 for one stop bit, 1 for two).
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  state_t     state;
  state_t     state_next;
  logic [9:0] cnt;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       last;
  logic       tick;
  logic       accept0;
  logic       accept1;
  logic       accept;

  assign accept0 = valid0 & ready0;
  assign accept1 = valid1 & ready1;
  assign accept  = accept0 | accept1;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every non-idle transition happens on a baud tick, so
  // each state lasts a whole number of bit periods.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: if (tick) state_next = DATA;
      DATA:  if (tick && (bit_idx == 3'd7)) state_next = STOP;
      STOP:  if (tick && (stop_idx == STOP_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The ready terms are gated by nrst so that no transfer is
  // signalled while reset is being held, even though the state reads IDLE.
  // On a tie the requester that was not served last wins.
  always_comb begin
    busy   = (state != IDLE);
    tick   = busy & (cnt == CNT_LAST);
    bdout  = tick;
    ready0 = nrst & (state == IDLE) & valid0 & (~valid1 | last);
    ready1 = nrst & (state == IDLE) & valid1 & (~valid0 | ~last);
    txd    = 1'b1;
    case (state)
      IDLE:  txd = 1'b1;
      START: txd = 1'b0;
      DATA:  txd = shreg[0];
      STOP:  txd = 1'b1;
      default: txd = 1'b1;
    endcase
  end

  // Datapath: baud counter, shift register, bit/stop indices and the
  // arbitration pointer. The counter is held at zero in IDLE so that the
  // first bit period of a frame starts exactly at the accept edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt      <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      gnt      <= 1'b0;
      last     <= 1'b1;
    end else if (state == IDLE) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      if (accept) begin
        shreg <= accept1 ? din1 : din0;
        gnt   <= accept1;
        last  <= accept1;
      end
    end else begin
      cnt <= tick ? 10'd0 : cnt + 10'd1;
      if (tick) begin
        case (state)
          DATA: begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          STOP: stop_idx <= ~stop_idx;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_bb_uart_tx_arb
//
// Purpose:
//   Self-checking bench for bb_uart_tx_arb with CLK_DIVIDER=4. The main
//   instance uses one stop bit; a second instance uses two stop bits.
//   Expected frames ({source, byte}) are queued when stimulus is queued and
//   compared by a serial decoder when the main instance finishes a frame.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_bb_uart_tx_arb;

  localparam int DIV = 4;

  logic       clk;
  logic       nrst;
  logic [7:0] din0, din1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       txd, busy, gnt, bdout;

  logic [7:0] din0b, din1b;
  logic       valid0b, valid1b;
  logic       ready0b, ready1b;
  logic       txdb, busyb, gntb, bdoutb;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [8:0] exp_q[$];
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];

  int abort_cnt     = 0;
  int idle_bd_cnt   = 0;
  int r0_pulses     = 0;
  int r1_pulses     = 0;
  int both_ready    = 0;
  int ready_busy    = 0;

  bb_uart_tx_arb #(.CLK_DIVIDER(DIV), .STOP_BITS(1)) u_dut (
    .clk   (clk),
    .nrst  (nrst),
    .din0  (din0),
    .valid0(valid0),
    .ready0(ready0),
    .din1  (din1),
    .valid1(valid1),
    .ready1(ready1),
    .txd   (txd),
    .busy  (busy),
    .gnt   (gnt),
    .bdout (bdout)
  );

  bb_uart_tx_arb #(.CLK_DIVIDER(DIV), .STOP_BITS(2)) u_dut2 (
    .clk   (clk),
    .nrst  (nrst),
    .din0  (din0b),
    .valid0(valid0b),
    .ready0(ready0b),
    .din1  (din1b),
    .valid1(valid1b),
    .ready1(ready1b),
    .txd   (txdb),
    .busy  (busyb),
    .gnt   (gntb),
    .bdout (bdoutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_compared++;
    if (got !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Presents the head of each source queue, holding valid until the byte is
  // taken. Called at a negedge; returns at a negedge once both queues drain.
  task automatic applyStimulus(input int budget);
    int  cyc;
    logic r0, r1;
    cyc = 0;
    forever begin
      valid0 = (src0_q.size() != 0);
      valid1 = (src1_q.size() != 0);
      din0   = valid0 ? src0_q[0] : 8'h00;
      din1   = valid1 ? src1_q[0] : 8'h00;
      if (!valid0 && !valid1) break;
      if (cyc == budget) begin
        checkOutput("stimulus_timeout", 32'd1, 32'd0);
        valid0 = 1'b0;
        valid1 = 1'b0;
        src0_q.delete();
        src1_q.delete();
        break;
      end
      #1;
      r0 = ready0;
      r1 = ready1;
      if (r0 && r1) both_ready++;
      if ((r0 || r1) && busy) ready_busy++;
      if (r0) r0_pulses++;
      if (r1) r1_pulses++;
      @(posedge clk);
      if (r0) void'(src0_q.pop_front());
      if (r1) void'(src1_q.pop_front());
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic waitDrain(input int budget);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && busy === 1'b0) break;
      cyc++;
      if (cyc == budget) begin
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
    end
  endtask

  // Serial decoder for the main instance: samples every cycle of a frame,
  // checks each bit is held for DIV cycles with bdout on its last cycle,
  // then checks the idle gap and compares against the scoreboard.
  always begin : monitor
    logic [9:0] bits;
    logic       unstable;
    logic       bd_bad;
    logic       aborted;
    logic       fr_gnt;
    logic [8:0] exp_item;
    int         bd_cnt;
    @(negedge clk);
    if (busy === 1'b1) begin
      bits     = '0;
      unstable = 1'b0;
      bd_bad   = 1'b0;
      aborted  = 1'b0;
      bd_cnt   = 0;
      fr_gnt   = gnt;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < DIV; c++) begin
          if (!aborted) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (busy !== 1'b1) begin
              aborted = 1'b1;
            end else begin
              if (c == 0) bits[b] = txd;
              else if (txd !== bits[b]) unstable = 1'b1;
              if (bdout === 1'b1) begin
                bd_cnt++;
                if (c != DIV - 1) bd_bad = 1'b1;
              end
            end
          end
        end
      end
      if (aborted) begin
        abort_cnt++;
      end else begin
        @(negedge clk);
        checkOutput("gap_busy", 32'(busy), 32'd0);
        checkOutput("gap_txd", 32'(txd), 32'd1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("frame_data", 32'(bits[8:1]), 32'(exp_item[7:0]));
          checkOutput("frame_gnt", 32'(fr_gnt), 32'(exp_item[8]));
          checkOutput("start_bit", 32'(bits[0]), 32'd0);
          checkOutput("stop_bit", 32'(bits[9]), 32'd1);
          checkOutput("bit_hold", 32'(unstable), 32'd0);
          checkOutput("bdout_count", 32'(bd_cnt), 32'd10);
          checkOutput("bdout_place", 32'(bd_bad), 32'd0);
        end
      end
    end else if (bdout !== 1'b0) begin
      idle_bd_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int low_cnt, high_cnt, busy_cnt, bd_cnt;
    nrst    = 1'b0;
    valid0  = 1'b1;
    din0    = 8'hA5;
    valid1  = 1'b0;
    din1    = 8'h00;
    valid0b = 1'b0;
    din0b   = 8'h00;
    valid1b = 1'b0;
    din1b   = 8'h00;

    // Reset held for three cycles while requester 0 is already asking.
    exp_q.push_back({1'b0, 8'hA5});
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_txd", 32'(txd), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_bdout", 32'(bdout), 32'd0);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_ready0", 32'(ready0), 32'd0);
      checkOutput("rst_ready1", 32'(ready1), 32'd0);
    end
    nrst = 1'b1;
    #1;
    checkOutput("first_ready0", 32'(ready0), 32'd1);
    checkOutput("first_ready1", 32'(ready1), 32'd0);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_txd", 32'(txd), 32'd0);
    checkOutput("accept_gnt", 32'(gnt), 32'd0);
    waitDrain(200);

    // Fresh reset so requester 0 wins the tie on the first simultaneous request.
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    src0_q.push_back(8'h55);
    src1_q.push_back(8'h0F);
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'h0F});
    applyStimulus(300);
    waitDrain(300);

    // Both requesters held for four frames: strict alternation.
    r0_pulses  = 0;
    r1_pulses  = 0;
    both_ready = 0;
    @(negedge clk);
    src0_q.push_back(8'h11);
    src0_q.push_back(8'h22);
    src1_q.push_back(8'h33);
    src1_q.push_back(8'h44);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h33});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h44});
    applyStimulus(600);
    waitDrain(300);
    checkOutput("ready0_pulses", 32'(r0_pulses), 32'd2);
    checkOutput("ready1_pulses", 32'(r1_pulses), 32'd2);
    checkOutput("both_ready", 32'(both_ready), 32'd0);

    // Reset during DATA bit 3 drops the frame; the next frame is intact.
    @(negedge clk);
    src0_q.push_back(8'h3C);
    applyStimulus(50);
    repeat (17) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_txd", 32'(txd), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    src1_q.push_back(8'hC3);
    exp_q.push_back({1'b1, 8'hC3});
    applyStimulus(50);
    waitDrain(200);
    checkOutput("abort_count", 32'(abort_cnt), 32'd1);
    checkOutput("ready_while_busy", 32'(ready_busy), 32'd0);
    checkOutput("idle_bdout", 32'(idle_bd_cnt), 32'd0);

    // Two stop bits with 0xFF: 4 low cycles then 40 high cycles.
    @(negedge clk);
    din0b   = 8'hFF;
    valid0b = 1'b1;
    #1;
    checkOutput("sb2_ready0", 32'(ready0b), 32'd1);
    @(posedge clk);
    #1;
    valid0b  = 1'b0;
    low_cnt  = 0;
    high_cnt = 0;
    busy_cnt = 0;
    bd_cnt   = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (busyb === 1'b1) busy_cnt++;
      if (bdoutb === 1'b1) bd_cnt++;
      if (i < 4 && txdb === 1'b0) low_cnt++;
      if (i >= 4 && txdb === 1'b1) high_cnt++;
    end
    @(negedge clk);
    checkOutput("sb2_start_low", 32'(low_cnt), 32'd4);
    checkOutput("sb2_high", 32'(high_cnt), 32'd40);
    checkOutput("sb2_busy", 32'(busy_cnt), 32'd44);
    checkOutput("sb2_bdout", 32'(bd_cnt), 32'd11);
    checkOutput("sb2_end_busy", 32'(busyb), 32'd0);
    checkOutput("sb2_gnt", 32'(gntb), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
